// File: rtl/sram_frame_reader_if.sv
// SRAM read-side bus and byte-stream handshake shared by the frame reader and its neighbours.
// The reader is the master: it drives the SRAM strobes and the byte stream.
interface sram_frame_reader_if;
    logic        CEb;
    logic        OEb;
    logic        BLEb;
    logic        BHEb;
    logic [15:0] sram_data;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;

    modport master (
        output CEb, OEb, BLEb, BHEb, pix_data, pix_valid,
        input  sram_data, pix_ready
    );

    modport slave (
        input  CEb, OEb, BLEb, BHEb, pix_data, pix_valid,
        output sram_data, pix_ready
    );
endinterface

// File: rtl/sram_frame_reader.sv
// Frame-buffer read-back: fetches word_count 16-bit words from async SRAM starting at
// base_addr and streams them low byte first over a valid/ready handshake.
module sram_frame_reader #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 16
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   word_count,
    output logic [ADDR_W-1:0]   Address,
    output logic                busy,
    output logic                done,
    sram_frame_reader_if.master bus
);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_OUT_LO,
        S_OUT_HI,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] remaining;
    logic [CNT_W-1:0]  wait_cnt;
    logic [15:0]       word;
    logic              sram_sel;
    logic              last_word;

    assign last_word = (remaining == ADDR_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of the order the processes are evaluated in.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        sram_sel      = 1'b0;
        bus.OEb       = 1'b1;
        bus.pix_valid = 1'b0;
        bus.pix_data  = 8'h00;
        busy          = (state != S_IDLE);
        done          = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (word_count == '0) ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                sram_sel  = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                sram_sel = 1'b1;
                bus.OEb  = 1'b0;
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_OUT_LO;
                end
            end
            S_OUT_LO: begin
                sram_sel      = 1'b1;
                bus.pix_valid = 1'b1;
                bus.pix_data  = word[7:0];
                if (bus.pix_ready) begin
                    state_nxt = S_OUT_HI;
                end
            end
            S_OUT_HI: begin
                sram_sel      = 1'b1;
                bus.pix_valid = 1'b1;
                bus.pix_data  = word[15:8];
                if (bus.pix_ready) begin
                    state_nxt = last_word ? S_DONE : S_SETUP;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Chip and byte enables stay asserted for the whole word so the address never glitches.
    assign bus.CEb  = ~sram_sel;
    assign bus.BLEb = ~sram_sel;
    assign bus.BHEb = ~sram_sel;
    assign Address  = sram_sel ? cur_addr : 'z;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
            word      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_addr  <= base_addr;
                        remaining <= word_count;
                    end
                end
                S_SETUP: wait_cnt <= '0;
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        word <= bus.sram_data;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_OUT_HI: begin
                    // Address wraps naturally at 2^ADDR_W.
                    if (bus.pix_ready && !last_word) begin
                        cur_addr  <= cur_addr + ADDR_W'(1);
                        remaining <= remaining - ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_frame_reader.sv
// Directed bench for sram_frame_reader: reset, single word, backpressure, wrap,
// zero count, reset during WAIT and start while busy.
module tb_sram_frame_reader;
    logic        pclk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] word_count;
    wire  [15:0] address;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [7:0]  byte_q[$];
    logic [15:0] addr_q[$];
    int done_cnt = 0;
    int oe_cnt   = 0;
    int ce_cnt   = 0;

    sram_frame_reader_if bus ();

    sram_frame_reader #(.WAIT_CYCLES(2), .ADDR_W(16)) dut (
        .pclk       (pclk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .Address    (address),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 pclk = ~pclk;

    function automatic logic [15:0] sram_word(input logic [15:0] a);
        case (a)
            16'h0010: return 16'hA55A;
            16'h0011: return 16'h7788;
            16'hFFFF: return 16'h1234;
            16'h0000: return 16'hBEEF;
            default:  return 16'hDEAD;
        endcase
    endfunction

    assign bus.sram_data = sram_word(address);

    // Observes the bus half a cycle away from the active edge.
    always @(negedge pclk) begin
        if (bus.pix_valid && bus.pix_ready) begin
            byte_q.push_back(bus.pix_data);
            addr_q.push_back(address);
        end
        if (done) done_cnt++;
        if (!bus.OEb) oe_cnt++;
        if (!bus.CEb) ce_cnt++;
    end

    function automatic logic [7:0] get_byte(input int idx);
        if (idx < byte_q.size()) return byte_q[idx];
        return 8'hxx;
    endfunction

    function automatic logic [15:0] get_addr(input int idx);
        if (idx < addr_q.size()) return addr_q[idx];
        return 16'hxxxx;
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] c);
        start      = 1'b1;
        base_addr  = b;
        word_count = c;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout done not seen within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; bus.pix_ready = 1'b1;
        #12;
        checks++; if ({bus.CEb, bus.OEb, bus.BLEb, bus.BHEb} !== 4'b1111) begin errors++; $display("FAIL reset_strobes got %b exp 1111", {bus.CEb, bus.OEb, bus.BLEb, bus.BHEb}); end
        checks++; if (bus.pix_valid !== 1'b0 || bus.pix_data !== 8'h00) begin errors++; $display("FAIL reset_pix got %b/%h exp 0/00", bus.pix_valid, bus.pix_data); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b/%b exp 0/0", busy, done); end
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        int n0 = byte_q.size();
        int d0 = done_cnt;
        int o0 = oe_cnt;
        bus.pix_ready = 1'b1;
        do_start(16'h0010, 16'd1);
        checks++; if (busy !== 1'b1 || bus.CEb !== 1'b0 || bus.OEb !== 1'b1 || bus.BLEb !== 1'b0 || bus.BHEb !== 1'b0) begin errors++; $display("FAIL single_setup got busy=%b ce=%b oe=%b ble=%b bhe=%b exp 1 0 1 0 0", busy, bus.CEb, bus.OEb, bus.BLEb, bus.BHEb); end
        checks++; if (address !== 16'h0010) begin errors++; $display("FAIL single_addr got %h exp 0010", address); end
        tick();
        checks++; if (bus.OEb !== 1'b0) begin errors++; $display("FAIL single_oe_w1 got %b exp 0", bus.OEb); end
        tick();
        checks++; if (bus.OEb !== 1'b0 || bus.pix_valid !== 1'b0) begin errors++; $display("FAIL single_oe_w2 got oe=%b valid=%b exp 0 0", bus.OEb, bus.pix_valid); end
        tick();
        checks++; if (bus.OEb !== 1'b1 || bus.pix_valid !== 1'b1 || bus.pix_data !== 8'h5A) begin errors++; $display("FAIL single_lo got oe=%b valid=%b data=%h exp 1 1 5a", bus.OEb, bus.pix_valid, bus.pix_data); end
        tick();
        checks++; if (bus.pix_valid !== 1'b1 || bus.pix_data !== 8'hA5) begin errors++; $display("FAIL single_hi got valid=%b data=%h exp 1 a5", bus.pix_valid, bus.pix_data); end
        tick();
        checks++; if (done !== 1'b1 || busy !== 1'b1 || bus.CEb !== 1'b1 || bus.pix_valid !== 1'b0) begin errors++; $display("FAIL single_done got done=%b busy=%b ce=%b valid=%b exp 1 1 1 0", done, busy, bus.CEb, bus.pix_valid); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got done=%b busy=%b exp 0 0", done, busy); end
        checks++; if (byte_q.size() - n0 != 2 || get_byte(n0) !== 8'h5A || get_byte(n0 + 1) !== 8'hA5) begin errors++; $display("FAIL single_bytes got n=%0d %h %h exp 2 5a a5", byte_q.size() - n0, get_byte(n0), get_byte(n0 + 1)); end
        checks++; if (oe_cnt - o0 != 2) begin errors++; $display("FAIL single_oe_len got %0d exp 2", oe_cnt - o0); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done_pulses got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_backpressure();
        logic [7:0]  exp_b[4] = '{8'h5A, 8'hA5, 8'h88, 8'h77};
        logic [15:0] exp_a[4] = '{16'h0010, 16'h0010, 16'h0011, 16'h0011};
        int n0 = byte_q.size();
        int d0 = done_cnt;
        bus.pix_ready = 1'b0;
        do_start(16'h0010, 16'd2);
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.pix_valid !== 1'b1 || bus.pix_data !== 8'h5A || address !== 16'h0010 || bus.CEb !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d got valid=%b data=%h addr=%h ce=%b exp 1 5a 0010 0", i, bus.pix_valid, bus.pix_data, address, bus.CEb); end
            if (i == 4) bus.pix_ready = 1'b1;
            tick();
        end
        wait_done("bp", 40);
        tick();
        checks++; if (byte_q.size() - n0 != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", byte_q.size() - n0); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (get_byte(n0 + i) !== exp_b[i] || get_addr(n0 + i) !== exp_a[i]) begin errors++; $display("FAIL bp_byte_%0d got %h@%h exp %h@%h", i, get_byte(n0 + i), get_addr(n0 + i), exp_b[i], exp_a[i]); end
        end
        checks++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin errors++; $display("FAIL bp_done got pulses=%0d busy=%b exp 1 0", done_cnt - d0, busy); end
    endtask

    task automatic test_wrap();
        logic [7:0]  exp_b[4] = '{8'h34, 8'h12, 8'hEF, 8'hBE};
        logic [15:0] exp_a[4] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
        int n0 = byte_q.size();
        int d0 = done_cnt;
        bus.pix_ready = 1'b1;
        do_start(16'hFFFF, 16'd2);
        wait_done("wrap", 40);
        tick();
        checks++; if (byte_q.size() - n0 != 4) begin errors++; $display("FAIL wrap_count got %0d exp 4", byte_q.size() - n0); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (get_byte(n0 + i) !== exp_b[i] || get_addr(n0 + i) !== exp_a[i]) begin errors++; $display("FAIL wrap_byte_%0d got %h@%h exp %h@%h", i, get_byte(n0 + i), get_addr(n0 + i), exp_b[i], exp_a[i]); end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL wrap_done got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_zero_count();
        int n0 = byte_q.size();
        int c0 = ce_cnt;
        int o0 = oe_cnt;
        do_start(16'h0010, 16'd0);
        checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL zero_done got done=%b busy=%b exp 1 1", done, busy); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_idle got done=%b busy=%b exp 0 0", done, busy); end
        tick();
        checks++; if (ce_cnt != c0 || oe_cnt != o0 || byte_q.size() != n0) begin errors++; $display("FAIL zero_no_access got ce=%0d oe=%0d bytes=%0d exp 0 0 0", ce_cnt - c0, oe_cnt - o0, byte_q.size() - n0); end
    endtask

    task automatic test_reset_mid_wait();
        int n0 = byte_q.size();
        int d0 = done_cnt;
        bus.pix_ready = 1'b1;
        do_start(16'h0010, 16'd2);
        tick();
        checks++; if (bus.OEb !== 1'b0) begin errors++; $display("FAIL rstw_pre_oe got %b exp 0", bus.OEb); end
        #3 rst = 1'b1;
        #1;
        checks++; if ({bus.CEb, bus.OEb, bus.BLEb, bus.BHEb} !== 4'b1111) begin errors++; $display("FAIL rstw_strobes got %b exp 1111", {bus.CEb, bus.OEb, bus.BLEb, bus.BHEb}); end
        checks++; if (bus.pix_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstw_outputs got valid=%b busy=%b done=%b exp 0 0 0", bus.pix_valid, busy, done); end
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (byte_q.size() != n0 || done_cnt != d0 || busy !== 1'b0) begin errors++; $display("FAIL rstw_idle got bytes=%0d done=%0d busy=%b exp 0 0 0", byte_q.size() - n0, done_cnt - d0, busy); end
    endtask

    task automatic test_start_while_busy();
        int n0 = byte_q.size();
        int d0 = done_cnt;
        bus.pix_ready = 1'b1;
        do_start(16'h0010, 16'd1);
        do_start(16'hFFFF, 16'd2);
        wait_done("swb", 40);
        for (int i = 0; i < 8; i++) tick();
        checks++; if (byte_q.size() - n0 != 2 || get_byte(n0) !== 8'h5A || get_byte(n0 + 1) !== 8'hA5) begin errors++; $display("FAIL swb_bytes got n=%0d %h %h exp 2 5a a5", byte_q.size() - n0, get_byte(n0), get_byte(n0 + 1)); end
        checks++; if (get_addr(n0) !== 16'h0010) begin errors++; $display("FAIL swb_addr got %h exp 0010", get_addr(n0)); end
        checks++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin errors++; $display("FAIL swb_done got pulses=%0d busy=%b exp 1 0", done_cnt - d0, busy); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_reset_mid_wait();
        test_start_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
